// File: rtl/video_stream_receiver_pkg.sv
// Shared constants for the video stream receiver: widths, error bit
// positions, FSM encodings and beat flag struct.
package video_stream_receiver_pkg;

  localparam int VRX_DATA_W     = 32;
  localparam int VRX_OUT_W      = 512;
  localparam int VRX_WPB        = VRX_OUT_W / VRX_DATA_W;
  localparam int VRX_KEEP_W     = VRX_DATA_W / 8;
  localparam int VRX_LINE_WORDS = 320;

  // sticky error vector layout: {line_len_err, sof_err, keep_err}
  localparam int ERR_KEEP = 0;
  localparam int ERR_SOF  = 1;
  localparam int ERR_LINE = 2;

  // FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PACK = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef struct packed {
    logic sof;
    logic last;
  } beat_flags_t;

  // every byte lane of the word must be kept
  function automatic logic keep_full(input logic [VRX_KEEP_W-1:0] keep);
    return &keep;
  endfunction

endpackage

// File: rtl/video_stream_receiver_if.sv
// Stream-in / beat-out bus of the video stream receiver. The slave modport
// is the receiver; the master modport is the source/sink environment.
interface video_stream_receiver_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 512
);
  logic                s_axis_tvalid;
  logic [DATA_W-1:0]   s_axis_tdata;
  logic [DATA_W/8-1:0] s_axis_tkeep;
  logic                s_axis_tlast;
  logic                s_axis_tuser;
  logic                s_axis_tready;

  logic                o_valid;
  logic [OUT_W-1:0]    o_data;
  logic                o_last;
  logic                o_sof;
  logic                i_ready;
  logic [15:0]         o_frame_cnt;
  logic [2:0]          o_err;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, i_ready,
    output s_axis_tready, o_valid, o_data, o_last, o_sof, o_frame_cnt, o_err
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, i_ready,
    input  s_axis_tready, o_valid, o_data, o_last, o_sof, o_frame_cnt, o_err
  );
endinterface

// File: rtl/video_stream_receiver_word_packer.sv
// Word packer: indexed register of WPB stream words plus the fill count.
// Slots above the fill count are always zero because the register is
// cleared after every completed beat, which gives zero-fill for free.
// first_i restarts the beat with the incoming word at slot 0; park_i keeps
// the merged beat in place (count reset) while it waits for the output.
module video_stream_receiver_word_packer
  import video_stream_receiver_pkg::*;
#(
  parameter  int DATA_W = VRX_DATA_W,
  parameter  int WPB    = VRX_WPB,
  localparam int CNT_W  = $clog2(WPB)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         wr_i,
  input  logic                         first_i,
  input  logic                         park_i,
  input  logic [DATA_W-1:0]            word_i,
  output logic [WPB-1:0][DATA_W-1:0]   beat_o,
  output logic [WPB-1:0][DATA_W-1:0]   beat_nxt_o,
  output logic [CNT_W-1:0]             cnt_o,
  output logic                         done_o
);

  logic [WPB-1:0][DATA_W-1:0] words_q, words_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           idx;

  assign idx    = first_i ? '0 : cnt_q;
  assign done_o = (idx == CNT_W'(WPB - 1));
  assign beat_o = words_q;
  assign cnt_o  = cnt_q;

  // per-slot merge of the incoming word; a restart drops the partial beat
  for (genvar k = 0; k < WPB; k++) begin : g_slot
    assign beat_nxt_o[k] = first_i ? ((k == 0) ? word_i : '0)
                         : (cnt_q == CNT_W'(k)) ? word_i : words_q[k];
  end

  // next register contents: clear wins over write
  always_comb begin
    words_d = words_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      words_d = '0;
      cnt_d   = '0;
    end else if (wr_i) begin
      words_d = beat_nxt_o;
      cnt_d   = park_i ? '0 : idx + CNT_W'(1);
    end
  end

  // packer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      cnt_q   <= '0;
    end else begin
      words_q <= words_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/video_stream_receiver.sv
// Video stream receiver: aligns a 32-bit AXI4-Stream video feed to
// start-of-frame, packs words into 512-bit beats (flushing at end of line)
// and presents them on a valid/ready port towards DDR write-back.
// Optional: VIDEO_RX_STATS_EN adds the frame counter and line length check.
module video_stream_receiver
  import video_stream_receiver_pkg::*;
#(
  parameter int DATA_W     = VRX_DATA_W,
  parameter int OUT_W      = VRX_OUT_W,
  parameter int LINE_WORDS = VRX_LINE_WORDS
) (
  input  logic                     system_clk,
  input  logic                     system_rst,
  video_stream_receiver_if.slave   bus
);

  localparam int WPB   = OUT_W / DATA_W;
  localparam int CNT_W = $clog2(WPB);

  logic [1:0]        state_q, state_d;
  logic              tready_q, tready_d;
  logic              o_valid_q, o_valid_d;
  logic [OUT_W-1:0]  o_data_q, o_data_d;
  beat_flags_t       out_flags_q, out_flags_d;
  beat_flags_t       hold_flags_q, hold_flags_d;
  logic              sof_pend_q, sof_pend_d;
  logic [2:0]        err_q, err_d;

  logic                       pk_clr, pk_wr, pk_park, pk_done;
  logic [WPB-1:0][DATA_W-1:0] pk_beat, pk_nxt;
  logic [CNT_W-1:0]           pk_cnt;

  logic accept, take, out_free, first, beat_done, beat_sof, line_err;

  assign accept    = bus.s_axis_tvalid & tready_q;
  // in IDLE only a start-of-frame word is kept; everything else is dropped
  assign take      = accept & ((state_q == ST_PACK) |
                               ((state_q == ST_IDLE) & bus.s_axis_tuser));
  assign out_free  = ~o_valid_q | bus.i_ready;
  assign first     = bus.s_axis_tuser;
  assign beat_done = pk_done | bus.s_axis_tlast;
  assign beat_sof  = first | sof_pend_q;

  video_stream_receiver_word_packer #(
    .DATA_W (DATA_W),
    .WPB    (WPB)
  ) u_packer (
    .clk        (system_clk),
    .rst        (system_rst),
    .clr_i      (pk_clr),
    .wr_i       (pk_wr),
    .first_i    (first),
    .park_i     (pk_park),
    .word_i     (bus.s_axis_tdata),
    .beat_o     (pk_beat),
    .beat_nxt_o (pk_nxt),
    .cnt_o      (pk_cnt),
    .done_o     (pk_done)
  );

  // FSM, output register loading and sticky sof/keep errors
  always_comb begin
    state_d      = state_q;
    o_valid_d    = o_valid_q & ~bus.i_ready;
    o_data_d     = o_data_q;
    out_flags_d  = out_flags_q;
    hold_flags_d = hold_flags_q;
    sof_pend_d   = sof_pend_q;
    err_d        = err_q;
    pk_clr       = 1'b0;
    pk_wr        = 1'b0;
    pk_park      = 1'b0;
    err_d[ERR_LINE] = err_q[ERR_LINE] | line_err;
    case (state_q)
      ST_IDLE, ST_PACK: begin
        if (take) begin
          state_d = ST_PACK;
          // a new frame start on top of a partial beat abandons that beat
          if (first && (pk_cnt != '0)) err_d[ERR_SOF] = 1'b1;
          if (!keep_full(bus.s_axis_tkeep)) err_d[ERR_KEEP] = 1'b1;
          if (beat_done) begin
            sof_pend_d = 1'b0;
            if (out_free) begin
              o_valid_d   = 1'b1;
              o_data_d    = pk_nxt;
              out_flags_d = '{sof: beat_sof, last: bus.s_axis_tlast};
              pk_clr      = 1'b1;
            end else begin
              // output busy: keep the finished beat in the packer and stall
              pk_wr        = 1'b1;
              pk_park      = 1'b1;
              hold_flags_d = '{sof: beat_sof, last: bus.s_axis_tlast};
              state_d      = ST_HOLD;
            end
          end else begin
            pk_wr      = 1'b1;
            sof_pend_d = beat_sof;
          end
        end
      end
      ST_HOLD: begin
        if (out_free) begin
          o_valid_d   = 1'b1;
          o_data_d    = pk_beat;
          out_flags_d = hold_flags_q;
          pk_clr      = 1'b1;
          state_d     = ST_PACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tready_d = (state_d != ST_HOLD);
  end

  // control and output registers
  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      state_q      <= ST_IDLE;
      tready_q     <= 1'b0;
      o_valid_q    <= 1'b0;
      o_data_q     <= '0;
      out_flags_q  <= '0;
      hold_flags_q <= '0;
      sof_pend_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      tready_q     <= tready_d;
      o_valid_q    <= o_valid_d;
      o_data_q     <= o_data_d;
      out_flags_q  <= out_flags_d;
      hold_flags_q <= hold_flags_d;
      sof_pend_q   <= sof_pend_d;
      err_q        <= err_d;
    end
  end

`ifdef VIDEO_RX_STATS_EN
  // line counter saturates one past the nominal length so overruns stay visible
  localparam int LCW = $clog2(LINE_WORDS + 2);

  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [LCW-1:0] line_cnt_q, line_cnt_d, line_nxt;

  // frame count and per-line word count; line_err pulses on a bad line
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;
    line_err    = 1'b0;
    if (first)
      line_nxt = LCW'(1);
    else if (line_cnt_q == LCW'(LINE_WORDS + 1))
      line_nxt = line_cnt_q;
    else
      line_nxt = line_cnt_q + LCW'(1);
    if (take) begin
      if (first) frame_cnt_d = frame_cnt_q + 16'd1;
      if (bus.s_axis_tlast) begin
        line_err   = (line_nxt != LCW'(LINE_WORDS));
        line_cnt_d = '0;
      end else begin
        line_err   = (line_nxt > LCW'(LINE_WORDS));
        line_cnt_d = line_nxt;
      end
    end
  end

  // stats registers
  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  assign bus.o_frame_cnt = frame_cnt_q;
`else
  assign line_err        = 1'b0;
  assign bus.o_frame_cnt = '0;
`endif

  assign bus.s_axis_tready = tready_q;
  assign bus.o_valid       = o_valid_q;
  assign bus.o_data        = o_data_q;
  assign bus.o_last        = out_flags_q.last;
  assign bus.o_sof         = out_flags_q.sof;
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_video_stream_receiver.sv
// Scoreboard bench for video_stream_receiver: stimulus pushes expected beats,
// a forked monitor pops and compares on every o_valid & i_ready handshake.
`timescale 1ns/1ps
module tb_video_stream_receiver;

`ifdef VIDEO_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic         sof;
    logic         last;
    logic [511:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  video_stream_receiver_if #(.DATA_W(32), .OUT_W(512)) vif();

  video_stream_receiver dut (
    .system_clk (clk),
    .system_rst (rst),
    .bus        (vif)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_beats = 0;
  bit   rnd_rdy = 1'b0;
  bit   gap_en  = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk(input logic [31:0] base, input int n);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d[32*k +: 32] = base + 32'(k);
    return d;
  endfunction

  // called at posedge+1, returns at posedge+1 after the word is accepted
  task automatic send(input logic [31:0] d, input logic last, input logic user,
                      input logic [3:0] keep);
    int  to;
    logic acc;
    if (gap_en && ($urandom_range(0, 3) == 0)) begin
      @(posedge clk); #1;
    end
    vif.s_axis_tvalid = 1'b1;
    vif.s_axis_tdata  = d;
    vif.s_axis_tlast  = last;
    vif.s_axis_tuser  = user;
    vif.s_axis_tkeep  = keep;
    to  = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = vif.s_axis_tready;
      @(posedge clk); #1;
      if (!acc) begin
        to++;
        if (to > 2000) begin
          n_cmp++; n_bad++;
          $display("FAIL send_timeout: word %0h not accepted, want accept within 2000 cycles", d);
          break;
        end
      end
    end
    vif.s_axis_tvalid = 1'b0;
    vif.s_axis_tlast  = 1'b0;
    vif.s_axis_tuser  = 1'b0;
    vif.s_axis_tkeep  = 4'hF;
  endtask

  // n consecutive words base+i; beats expected as 16-word groups, zero-filled
  task automatic line(input logic [31:0] base, input int n, input bit user_first,
                      input bit with_last, input int keep_at);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if ((i % 16) == 0 && ((n - i) >= 16 || with_last)) begin
        e.sof  = user_first && (i == 0);
        e.last = with_last && ((n - i) <= 16);
        e.data = mk(base + 32'(i), ((n - i) < 16) ? (n - i) : 16);
        q.push_back(e);
      end
      send(base + 32'(i), with_last && (i == n - 1), user_first && (i == 0),
           (i == keep_at) ? 4'h3 : 4'hF);
    end
  endtask

  task automatic monitor();
    exp_t a, e;
    forever begin
      @(negedge clk);
      if (vif.o_valid && vif.i_ready) begin
        a.sof  = vif.o_sof;
        a.last = vif.o_last;
        a.data = vif.o_data;
        n_cmp++;
        n_beats++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL beat_unexpected: got sof=%0b last=%0b data=%h, want no beat",
                   a.sof, a.last, a.data);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            n_bad++;
            $display("FAIL beat: got sof=%0b last=%0b data=%h want sof=%0b last=%0b data=%h",
                     a.sof, a.last, a.data, e.sof, e.last, e.data);
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) vif.i_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic drain(input string tag);
    int to;
    to = 0;
    while (q.size() != 0 && to < 5000) begin
      @(posedge clk);
      to++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_pending_beats"}, 512'(q.size()), 512'(0));
  endtask

  // called at posedge+1; checks reset values then release behaviour
  task automatic do_reset(input string tag);
    rst = 1'b1;
    vif.s_axis_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_tready"},    512'(vif.s_axis_tready), 512'(0));
    chk({tag, "_o_valid"},   512'(vif.o_valid),       512'(0));
    chk({tag, "_o_data"},    vif.o_data,              512'(0));
    chk({tag, "_o_last"},    512'(vif.o_last),        512'(0));
    chk({tag, "_o_sof"},     512'(vif.o_sof),         512'(0));
    chk({tag, "_frame_cnt"}, 512'(vif.o_frame_cnt),   512'(0));
    chk({tag, "_o_err"},     512'(vif.o_err),         512'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_tready_idle"}, 512'(vif.s_axis_tready), 512'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    vif.s_axis_tvalid = 1'b0;
    vif.s_axis_tdata  = '0;
    vif.s_axis_tkeep  = 4'hF;
    vif.s_axis_tlast  = 1'b0;
    vif.s_axis_tuser  = 1'b0;
    vif.i_ready       = 1'b1;
    fork
      monitor();
      ready_drv();
    join_none

    do_reset("rst0");

    // T1: 32-word line opened by tuser -> two beats, sof on first, last on second
    line(32'h1000_0000, 32, 1'b1, 1'b1, -1);
    // T2: 20-word line -> full beat then 4 words + 12 zero words with last
    line(32'h2000_0000, 20, 1'b0, 1'b1, -1);
    drain("t2");
    chk("t2_err", 512'(vif.o_err), STATS ? 512'(3'b100) : 512'(0));
    chk("t2_frame_cnt", 512'(vif.o_frame_cnt), STATS ? 512'(1) : 512'(0));

    // T3: sink stalled for 40 cycles while a 48-word line streams in
    vif.i_ready = 1'b0;
    fork
      line(32'h3000_0000, 48, 1'b0, 1'b1, -1);
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t3_tready_stall", 512'(vif.s_axis_tready), 512'(0));
        chk("t3_valid_held",   512'(vif.o_valid),       512'(1));
        chk("t3_data_held",    vif.o_data,              mk(32'h3000_0000, 16));
        chk("t3_last_held",    512'(vif.o_last),        512'(0));
        @(posedge clk); #1;
        vif.i_ready = 1'b1;
      end
    join
    drain("t3");

    // T5: one word with tkeep=3 inside a full beat, then reset mid-line
    line(32'h5000_0000, 19, 1'b0, 1'b0, 5);
    drain("t5");
    chk("t5_err_keep", 512'(vif.o_err), STATS ? 512'(3'b101) : 512'(3'b001));
    do_reset("rst_mid");

    // T4: pre-frame words dropped; tuser at word 7 restarts the beat
    for (int i = 0; i < 5; i++) send(32'h4000_0000 + 32'(i), 1'b0, 1'b0, 4'hF);
    @(negedge clk);
    chk("t4_no_valid", 512'(vif.o_valid), 512'(0));
    chk("t4_err_clean", 512'(vif.o_err), 512'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) send(32'h4100_0000 + 32'(i), 1'b0, (i == 0), 4'hF);
    line(32'h4200_0000, 16, 1'b1, 1'b1, -1);
    drain("t4");
    chk("t4_err_sof", 512'(vif.o_err), STATS ? 512'(3'b110) : 512'(3'b010));
    chk("t4_frame_cnt", 512'(vif.o_frame_cnt), STATS ? 512'(2) : 512'(0));

    // T6: 3 frames x 5 lines x 320 words with random stalls on both sides
    do_reset("rst6");
    n_beats = 0;
    rnd_rdy = 1'b1;
    gap_en  = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int l = 0; l < 5; l++)
        line(32'h6000_0000 + (32'(f) << 16) + (32'(l) << 9), 320, (l == 0), 1'b1, -1);
    rnd_rdy = 1'b0;
    gap_en  = 1'b0;
    @(posedge clk); #2;
    vif.i_ready = 1'b1;
    drain("t6");
    chk("t6_beats", 512'(n_beats), 512'(300));
    chk("t6_err", 512'(vif.o_err), 512'(0));
    chk("t6_frame_cnt", 512'(vif.o_frame_cnt), STATS ? 512'(3) : 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
